// File: rtl/program_sequencer_ps2.sv
// program_sequencer_ps2 -- program counter / fetch-address generator.
// Handles jump, conditional jump, timed wait (HOLD) and a call/return stack
// with sticky overflow and underflow flags.
// Optional build macro PS_DEBUG_EN exposes internal state on from_PS.
// Without the macro, from_PS is tied to 8'h00.
module program_sequencer_ps2 #(
  parameter int ADDR_W      = 8,
  parameter int JADDR_W     = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               sync_reset,
  input  logic               jmp,
  input  logic               jmp_nz,
  input  logic               dont_jmp,
  input  logic               wait_en,
  input  logic               call,
  input  logic               ret,
  input  logic [JADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               stack_empty,
  output logic               stack_ovf,
  output logic               stack_unf,
  output logic [7:0]         from_PS
);

  // The pointer can reach STACK_DEPTH, so it needs one extra code point.
  // Storage is rounded up to a power of two so the pointer indexes it
  // directly; the slots beyond STACK_DEPTH are never written.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int SLOTS = 1 << SP_W;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [JADDR_W-1:0] timer_q;
  logic [SP_W-1:0]    sp_q;
  logic               ovf_q;
  logic               unf_q;
  logic [ADDR_W-1:0]  stack_q [SLOTS];

  logic [ADDR_W-1:0]  pc_inc_s;
  logic [ADDR_W-1:0]  target_s;
  logic [SP_W-1:0]    top_idx_s;
  logic               empty_s;
  logic               full_s;

  logic [ADDR_W-1:0]  next_addr_d;
  logic               push_s;
  logic               pop_s;
  logic               set_ovf_s;
  logic               set_unf_s;
  logic               start_wait_s;

  assign pc_inc_s  = pc_q + ADDR_W'(1);
  assign target_s  = ADDR_W'(jmp_addr) << (ADDR_W - JADDR_W);
  assign top_idx_s = sp_q - SP_W'(1);
  assign empty_s   = (sp_q == SP_W'(0));
  assign full_s    = (sp_q == SP_W'(STACK_DEPTH));

  // Priority next-address mux and decode of the single winning action.
  always_comb begin
    next_addr_d  = pc_inc_s;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    set_ovf_s    = 1'b0;
    set_unf_s    = 1'b0;
    start_wait_s = 1'b0;
    if (sync_reset) begin
      next_addr_d = '0;
    end else if (state_q == HOLD) begin
      next_addr_d = pc_inc_s;
    end else if (ret) begin
      if (!empty_s) begin
        next_addr_d = stack_q[top_idx_s];
        pop_s       = 1'b1;
      end else begin
        next_addr_d = pc_inc_s;
        set_unf_s   = 1'b1;
      end
    end else if (call) begin
      next_addr_d = target_s;
      if (!full_s) begin
        push_s = 1'b1;
      end else begin
        set_ovf_s = 1'b1;
      end
    end else if (jmp) begin
      next_addr_d = target_s;
    end else if (jmp_nz && !dont_jmp) begin
      next_addr_d = target_s;
    end else if (wait_en && (jmp_addr != JADDR_W'(0))) begin
      // The fetch address stays on the current instruction while waiting.
      next_addr_d  = pc_q;
      start_wait_s = 1'b1;
    end else begin
      next_addr_d = pc_inc_s;
    end
  end

  // Sequencer FSM: program counter, wait timer, stack pointer and flags.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      timer_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          pc_q <= next_addr_d;
          if (start_wait_s) begin
            state_q <= HOLD;
            timer_q <= jmp_addr - JADDR_W'(1);
          end
          if (push_s) begin
            sp_q <= sp_q + SP_W'(1);
          end else if (pop_s) begin
            sp_q <= top_idx_s;
          end
          ovf_q <= ovf_q | set_ovf_s;
          unf_q <= unf_q | set_unf_s;
        end
        HOLD: begin
          // The exit edge accepts pc+1, so a wait of N holds pc for N edges.
          if (timer_q != JADDR_W'(0)) begin
            timer_q <= timer_q - JADDR_W'(1);
          end else begin
            state_q <= RUN;
            pc_q    <= next_addr_d;
          end
        end
        default: begin
          state_q <= RUN;
          timer_q <= '0;
        end
      endcase
    end
  end

  // Return-address storage; only the pointer is reset, entries are not.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_q[sp_q] <= pc_inc_s;
    end
  end

  assign pm_addr     = next_addr_d;
  assign pc          = pc_q;
  assign stack_empty = empty_s;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

`ifdef PS_DEBUG_EN
  logic [3:0] timer4_s;
  if (JADDR_W >= 4) begin : g_tmr_trunc
    assign timer4_s = timer_q[3:0];
  end else begin : g_tmr_ext
    assign timer4_s = {{(4 - JADDR_W){1'b0}}, timer_q};
  end
  assign from_PS = {(state_q == HOLD), ovf_q, unf_q, empty_s, timer4_s};
`else
  assign from_PS = 8'h00;
`endif

endmodule
